// File: rtl/text_pkg.sv
// Shared constants, control codes, FSM state type and cell-address helper
// for the character-cell text buffer.
// Optional feature macro: TEXT_SCROLL_EN (adds the SCROLL state).
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

`ifdef TEXT_SCROLL_EN
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL} state_t;
`else
  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;
`endif

  // row*80 + col using shifts, full 12-bit width so no cell below 2400 aliases
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                  input logic [6:0] col);
    logic [ADDR_W-1:0] w_r;
    w_r = {6'b0, row};
    return (w_r << 6) + (w_r << 4) + {5'b0, col};
  endfunction

endpackage

// File: rtl/text_ram.sv
// Dual-port character RAM with synchronous reads.
// Port A: display read. Port B: writer write, plus read under TEXT_SCROLL_EN.
// A read on port A of an address written in the same cycle returns old data.
module text_ram
  import text_pkg::*;
#(
  parameter int DEPTH = CELLS,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [7:0]    i_d_b,
`ifdef TEXT_SCROLL_EN
  output logic [7:0]    o_q_b,
`endif
  input  logic          i_re_a,
  input  logic [AW-1:0] i_addr_a,
  output logic [7:0]    o_q_a
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q_a;
`ifdef TEXT_SCROLL_EN
  logic [7:0] r_q_b;
`endif

  // Read-before-write memory: both ports sample the old contents
  always_ff @(posedge clk) begin
    if (i_re_a) begin
      r_q_a <= r_mem[i_addr_a];
    end
    if (i_we_b) begin
      r_mem[i_addr_b] <= i_d_b;
    end
`ifdef TEXT_SCROLL_EN
    r_q_b <= r_mem[i_addr_b];
`endif
  end

  assign o_q_a = r_q_a;
`ifdef TEXT_SCROLL_EN
  assign o_q_b = r_q_b;
`endif

endmodule

// File: rtl/text_buffer.sv
// 80x30 character-cell text buffer: terminal-style writer FSM with cursor,
// plus a 2-cycle display read path aligned with delayed x/y/video_on.
// Optional feature macro: TEXT_SCROLL_EN (scroll up at the last row instead
// of wrapping the cursor to row 0).
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  output logic [7:0] ascii_char,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       video_on_out,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  import text_pkg::*;

  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
`ifdef TEXT_SCROLL_EN
  localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
`endif

  // Writer state
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [6:0]        r_col;
  logic [4:0]        r_row;
  logic              r_wr_ready;
  logic              r_busy;
`ifdef TEXT_SCROLL_EN
  logic              r_ph;
  logic [7:0]        w_q_b;
`endif

  // Writer port signals
  logic              w_xfer;
  logic              w_print;
  logic              w_adv;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_bs_addr;
  logic              w_we_b;
  logic [ADDR_W-1:0] w_addr_b;
  logic [7:0]        w_d_b;

  // Display path signals
  logic [6:0]        w_dcol;
  logic [5:0]        w_drow;
  logic              w_in_grid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic [9:0]        r_x1;
  logic [9:0]        r_y1;
  logic              r_von1;
  logic              r_oob2;
  logic [9:0]        r_x2;
  logic [9:0]        r_y2;
  logic              r_von2;
  logic [7:0]        w_q_a;

  assign w_xfer     = wr_valid && r_wr_ready;
  assign w_print    = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign w_adv      = w_xfer && ((w_print && (r_col == LAST_COL)) || (wr_char == CH_LF));
  assign w_cur_addr = cell_addr({1'b0, r_row}, r_col);
  assign w_bs_addr  = cell_addr({1'b0, r_row}, r_col - 7'd1);

  // Writer RAM port: clear fill, character/backspace writes, scroll copy
  always_comb begin
    w_we_b   = 1'b0;
    w_addr_b = w_cur_addr;
    w_d_b    = CH_SPACE;
    case (r_state)
      ST_CLEAR: begin
        w_we_b   = 1'b1;
        w_addr_b = r_cnt;
      end
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_print) begin
            w_we_b = 1'b1;
            w_d_b  = wr_char;
          end else if ((wr_char == CH_BS) && (r_col != '0)) begin
            w_we_b   = 1'b1;
            w_addr_b = w_bs_addr;
          end
        end
      end
`ifdef TEXT_SCROLL_EN
      ST_SCROLL: begin
        if (r_cnt < SCROLL_END) begin
          // phase 0 reads the cell one row below, phase 1 writes it here
          if (!r_ph) begin
            w_addr_b = r_cnt + COLS_A;
          end else begin
            w_we_b   = 1'b1;
            w_addr_b = r_cnt;
            w_d_b    = w_q_b;
          end
        end else begin
          w_we_b   = 1'b1;
          w_addr_b = r_cnt;
        end
      end
`endif
      default: ;
    endcase
  end

  // Writer FSM with registered ready/busy and cursor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b1;
`ifdef TEXT_SCROLL_EN
      r_ph       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_col <= '0;
          r_row <= '0;
          if (r_cnt == LAST_CELL) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_xfer) begin
            if (wr_char == CH_FF) begin
              r_state    <= ST_CLEAR;
              r_cnt      <= '0;
              r_col      <= '0;
              r_row      <= '0;
              r_wr_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              if (w_print) begin
                r_col <= (r_col == LAST_COL) ? '0 : r_col + 7'd1;
              end else if ((wr_char == CH_LF) || (wr_char == CH_CR)) begin
                r_col <= '0;
              end else if ((wr_char == CH_BS) && (r_col != '0)) begin
                r_col <= r_col - 7'd1;
              end
              if (w_adv) begin
                if (r_row != LAST_ROW) begin
                  r_row <= r_row + 5'd1;
                end else begin
`ifdef TEXT_SCROLL_EN
                  r_state    <= ST_SCROLL;
                  r_cnt      <= '0;
                  r_ph       <= 1'b0;
                  r_wr_ready <= 1'b0;
                  r_busy     <= 1'b1;
`else
                  r_row <= '0;
`endif
                end
              end
            end
          end
        end
`ifdef TEXT_SCROLL_EN
        ST_SCROLL: begin
          if (r_cnt < SCROLL_END) begin
            r_ph <= ~r_ph;
            if (r_ph) begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end else if (r_cnt == LAST_CELL) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
`endif
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign w_dcol    = x[9:3];
  assign w_drow    = y[9:4];
  assign w_in_grid = (w_dcol < 7'(COLS)) && (w_drow < 6'(ROWS));

  // Display pipeline: stage 1 registers the cell address, stage 2 is the RAM read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_von1    <= 1'b0;
      r_oob2    <= 1'b1;
      r_x2      <= '0;
      r_y2      <= '0;
      r_von2    <= 1'b0;
    end else begin
      r_rd_addr <= w_in_grid ? cell_addr(w_drow, w_dcol) : '0;
      r_rd_en   <= w_in_grid;
      r_x1      <= x;
      r_y1      <= y;
      r_von1    <= video_on;
      r_oob2    <= !r_rd_en;
      r_x2      <= r_x1;
      r_y2      <= r_y1;
      r_von2    <= r_von1;
    end
  end

  text_ram #(
    .DEPTH (COLS * ROWS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .i_we_b   (w_we_b),
    .i_addr_b (w_addr_b),
    .i_d_b    (w_d_b),
`ifdef TEXT_SCROLL_EN
    .o_q_b    (w_q_b),
`endif
    .i_re_a   (w_in_grid_q()),
    .i_addr_a (r_rd_addr),
    .o_q_a    (w_q_a)
  );

  function automatic logic w_in_grid_q();
    return r_rd_en;
  endfunction

  assign ascii_char   = r_oob2 ? CH_SPACE : w_q_a;
  assign x_out        = r_x2;
  assign y_out        = r_y2;
  assign video_on_out = r_von2;
  assign cursor_col   = r_col;
  assign cursor_row   = r_row;
  assign wr_ready     = r_wr_ready;
  assign busy         = r_busy;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: randomized character stream and display
// coordinates against a behavioural screen model, plus directed literal checks.
// Honours TEXT_SCROLL_EN for the last-row behaviour.
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [9:0] x, y, x_out, y_out;
  logic       video_on, video_on_out;
  logic [7:0] ascii_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  always #5 clk = ~clk;

  text_buffer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .x(x), .y(y), .video_on(video_on),
    .ascii_char(ascii_char), .x_out(x_out), .y_out(y_out),
    .video_on_out(video_on_out), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy)
  );

`ifdef TEXT_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit hold;
  bit seen_low;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int x; int y; int von; int oob; int addr;} samp_t;
  int    mem [2400];
  int    m_row, m_col, m_busy;
  samp_t pipe[$];
  int    e_x, e_y, e_von, e_char;
  bit    e_chk;

  function automatic void adv_row();
    if (m_row < 29) m_row++;
    else if (SCROLL_ON) begin
      for (int i = 0; i < 2320; i++) mem[i] = mem[i + 80];
      for (int i = 2320; i < 2400; i++) mem[i] = 32;
      m_busy = 4720;
    end else m_row = 0;
  endfunction

  function automatic void apply(input int c);
    if (c >= 32 && c <= 126) begin
      mem[m_row * 80 + m_col] = c;
      if (m_col == 79) begin m_col = 0; adv_row(); end
      else m_col++;
    end else if (c == 10) begin
      m_col = 0; adv_row();
    end else if (c == 13) begin
      m_col = 0;
    end else if (c == 8) begin
      if (m_col > 0) begin m_col--; mem[m_row * 80 + m_col] = 32; end
    end else if (c == 12) begin
      for (int i = 0; i < 2400; i++) mem[i] = 32;
      m_row = 0; m_col = 0; m_busy = 2400;
    end
  endfunction

  function automatic void reset_model();
    samp_t s;
    s = '{x: 0, y: 0, von: 0, oob: 1, addr: 0};
    pipe.delete();
    pipe.push_back(s);
    e_x = 0; e_y = 0; e_von = 0; e_char = 32; e_chk = 1'b1;
    m_row = 0; m_col = 0; m_busy = 2400;
    for (int i = 0; i < 2400; i++) mem[i] = 32;
  endfunction

  function automatic void model_step();
    samp_t s, n;
    int c, r;
    s = pipe.pop_front();
    e_x = s.x; e_y = s.y; e_von = s.von;
    e_chk  = (s.oob != 0) || (m_busy == 0);
    e_char = (s.oob != 0) ? 32 : mem[s.addr];
    c = int'(x) / 8;
    r = int'(y) / 16;
    n.x = int'(x); n.y = int'(y); n.von = int'(video_on);
    n.oob = (c >= 80 || r >= 30) ? 1 : 0;
    n.addr = (n.oob != 0) ? 0 : r * 80 + c;
    pipe.push_back(n);
    if (m_busy > 0) m_busy--;
    else if (wr_valid) apply(int'(wr_char));
  endfunction

  // Compare process: every cycle, #1 after the active edge
  always @(posedge clk) begin
    if (reset) reset_model();
    else model_step();
    #1;
    check("wr_ready", wr_ready, m_busy == 0);
    check("busy", busy, m_busy != 0);
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
    check("x_out", x_out, e_x);
    check("y_out", y_out, e_y);
    check("video_on_out", video_on_out, e_von);
    if (e_chk) check("ascii_char", ascii_char, e_char);
  end

  // Background random display coordinates, including off-grid positions
  initial begin
    forever begin
      @(negedge clk);
      if (!hold) begin
        x = 10'($urandom_range(0, 799));
        y = 10'($urandom_range(0, 524));
        video_on = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push(input logic [7:0] c);
    int w;
    w = 0;
    wr_valid = 1'b1;
    wr_char  = c;
    while (wr_ready !== 1'b1 && w < 10000) begin
      seen_low = 1'b1;
      @(negedge clk);
      w++;
    end
    if (w >= 10000) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: ready never rose, char %0h", c);
    end
    @(negedge clk);
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    hold = 1'b1;
    x = 10'(c * 8 + $urandom_range(0, 7));
    y = 10'(r * 16 + $urandom_range(0, 15));
    video_on = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 v = ascii_char;
    @(negedge clk);
    hold = 1'b0;
  endtask

  function automatic logic [7:0] letter(input int r);
    return (r < 26) ? 8'(65 + r) : 8'(97 + r - 26);
  endfunction

  function automatic logic [7:0] rand_char();
    int p;
    logic [7:0] others [6];
    others = '{8'h00, 8'h01, 8'h1B, 8'h7F, 8'h80, 8'hFF};
    p = $urandom_range(0, 99);
    if (p < 70) return 8'($urandom_range(32, 126));
    else if (p < 78) return 8'h0A;
    else if (p < 83) return 8'h0D;
    else if (p < 90) return 8'h08;
    else if (p < 99) return others[$urandom_range(0, 5)];
    else return 8'h0C;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [7:0] v;
    reset = 1'b1; wr_valid = 1'b0; wr_char = 8'h00;
    x = '0; y = '0; video_on = 1'b0; hold = 1'b0; seen_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_low(n);
    check("clear_len_after_reset", n, 2400);

    // sweep every cell after the clear
    hold = 1'b1;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        x = 10'(c * 8 + $urandom_range(0, 7));
        y = 10'(r * 16 + $urandom_range(0, 15));
        video_on = 1'b1;
        @(negedge clk);
      end
    hold = 1'b0;
    read_cell(29, 79, v); check("cleared_cell_29_79", v, 8'h20);

    // "AB", LF, "C"
    push(8'h41); push(8'h42); push(8'h0A); push(8'h43);
    wr_valid = 1'b0;
    check("abc_cursor_row", cursor_row, 1);
    check("abc_cursor_col", cursor_col, 1);
    read_cell(0, 0, v); check("cell_0_0_A", v, 8'h41);
    read_cell(0, 1, v); check("cell_0_1_B", v, 8'h42);
    read_cell(1, 0, v); check("cell_1_0_C", v, 8'h43);

    // form feed, then 81 'X' back-to-back
    push(8'h0C); wr_valid = 1'b0;
    count_low(n); check("ff_clear_len", n, 2400);
    seen_low = 1'b0;
    for (int i = 0; i < 81; i++) push(8'h58);
    wr_valid = 1'b0;
    check("x81_ready_held", seen_low, 1'b0);
    check("x81_cursor_row", cursor_row, 1);
    check("x81_cursor_col", cursor_col, 1);
    read_cell(0, 79, v); check("x81_cell_0_79", v, 8'h58);
    read_cell(1, 0, v);  check("x81_cell_1_0", v, 8'h58);
    read_cell(1, 1, v);  check("x81_cell_1_1", v, 8'h20);

    // backspace at col 0, 'Q', backspace
    push(8'h0C); wr_valid = 1'b0; count_low(n);
    push(8'h08);
    check("bs_at_col0_col", cursor_col, 0);
    push(8'h51); push(8'h08); wr_valid = 1'b0;
    check("bs_cursor_row", cursor_row, 0);
    check("bs_cursor_col", cursor_col, 0);
    read_cell(0, 0, v); check("bs_cell_0_0", v, 8'h20);

    // fill all 30 rows, then LF at the last row
    push(8'h0C); wr_valid = 1'b0; count_low(n);
    for (int r = 0; r < 30; r++) begin
      push(letter(r));
      if (r < 29) push(8'h0A);
    end
    push(8'h0A); wr_valid = 1'b0;
    count_low(n);
`ifdef TEXT_SCROLL_EN
    check("scroll_len", n, 4720);
    check("scroll_cursor_row", cursor_row, 29);
    check("scroll_cursor_col", cursor_col, 0);
    read_cell(0, 0, v);  check("scroll_row0", v, letter(1));
    read_cell(28, 0, v); check("scroll_row28", v, letter(29));
    read_cell(29, 0, v); check("scroll_row29", v, 8'h20);
`else
    check("wrap_no_busy", n, 0);
    check("wrap_cursor_row", cursor_row, 0);
    check("wrap_cursor_col", cursor_col, 0);
    read_cell(0, 0, v);  check("wrap_row0_kept", v, letter(0));
    read_cell(29, 0, v); check("wrap_row29_kept", v, letter(29));
`endif

    // randomized character stream with idle gaps
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr_valid = 1'b0;
        wr_char = 8'($urandom);
        @(negedge clk);
      end
      push(rand_char());
    end
    wr_valid = 1'b0;
    count_low(n);

    // reset in the middle of a form-feed clear
    push(8'h41); push(8'h0C); wr_valid = 1'b0;
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_ready", wr_ready, 1'b0);
    reset = 1'b0;
    count_low(n);
    check("clear_len_after_midreset", n, 2400);
    check("midreset_cursor_row", cursor_row, 0);
    check("midreset_cursor_col", cursor_col, 0);
    read_cell(0, 0, v); check("midreset_cell_0_0", v, 8'h20);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
